// File: rtl/dot11_tx_pkg.sv
`default_nettype none
// ============================================================================
// dot11_tx_pkg : FSM encodings, scrambler seed constant and seed-step helper
//                shared by the 802.11 transmit scheduler.
// Rev 1.0
// ============================================================================
package dot11_tx_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE         = 3'd0;
  localparam state_t ST_START        = 3'd1;
  localparam state_t ST_WAIT_STARTED = 3'd2;
  localparam state_t ST_WAIT_DONE    = 3'd3;
  localparam state_t ST_GAP          = 3'd4;

  localparam logic [6:0] SCRAM_SEED_INIT = 7'h7F;

  // One step of x^7+x^4+1; the all-zero state would lock the scrambler.
  function automatic logic [6:0] scram_step(input logic [6:0] s);
    logic [6:0] n;
    n = {s[5:0], s[6] ^ s[3]};
    return (n == 7'h00) ? SCRAM_SEED_INIT : n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dot11_tx_sched_if.sv
`default_nettype none
// ============================================================================
// dot11_tx_sched_if : scheduler <-> OFDM transmitter control and seed bus.
// Rev 1.0
// ============================================================================
interface dot11_tx_sched_if;

  logic       phy_tx_start;
  logic       phy_tx_started;
  logic       phy_tx_done;
  logic [6:0] init_data_scram_state;
  logic [6:0] init_pilot_scram_state;

  modport master (
    output phy_tx_start,
    output init_data_scram_state,
    output init_pilot_scram_state,
    input  phy_tx_started,
    input  phy_tx_done
  );

  modport slave (
    input  phy_tx_start,
    input  init_data_scram_state,
    input  init_pilot_scram_state,
    output phy_tx_started,
    output phy_tx_done
  );

endinterface
`default_nettype wire

// File: rtl/dot11_tx_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin pick, searching upward from i_rr_ptr.
// Rev 1.0
// ============================================================================
module rr_arbiter #(
  parameter int NUM_Q = 4,
  parameter int QW    = $clog2(NUM_Q)
) (
  input  wire logic [NUM_Q-1:0] i_req,
  input  wire logic [QW-1:0]    i_rr_ptr,
  output logic      [NUM_Q-1:0] o_winner_oh,
  output logic      [QW-1:0]    o_winner_idx,
  output logic                  o_valid
);

  logic [QW-1:0] w_cand;
  logic [QW-1:0] w_idx;
  logic          w_found;

  // NUM_Q is a power of two, so QW-bit addition wraps exactly at NUM_Q.
  always_comb begin
    w_cand  = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_Q; i++) begin
      w_cand = i_rr_ptr + QW'(i);
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

  always_comb begin
    o_winner_oh        = '0;
    o_winner_oh[w_idx] = w_found;
  end

  assign o_winner_idx = w_idx;
  assign o_valid      = w_found;

endmodule
`default_nettype wire

// File: rtl/dot11_tx_sched.sv
`default_nettype none
// ============================================================================
// dot11_tx_sched : round-robin transmit scheduler driving one OFDM PHY,
//                  with start/done timeouts, inter-packet gap and seed update.
// Rev 1.0
// ============================================================================
module dot11_tx_sched
  import dot11_tx_pkg::*;
#(
  parameter int NUM_Q = 4,
  parameter int QW    = $clog2(NUM_Q)
) (
  input  wire logic             clk,
  input  wire logic             rstn,
  input  wire logic             enable,
  input  wire logic [NUM_Q-1:0] req,
  output logic      [NUM_Q-1:0] grant,
  output logic      [NUM_Q-1:0] done,
  output logic      [NUM_Q-1:0] err,
  output logic      [QW-1:0]    active_q,
  output logic                  busy,
  input  wire logic [15:0]      start_timeout,
  input  wire logic [23:0]      done_timeout,
  input  wire logic [7:0]       gap_cycles,
  dot11_tx_sched_if.master      phy
);

  state_t           r_state;
  logic [NUM_Q-1:0] r_grant;
  logic [NUM_Q-1:0] r_done;
  logic [NUM_Q-1:0] r_err;
  logic [QW-1:0]    r_active_q;
  logic [QW-1:0]    r_rr_ptr;
  logic [23:0]      r_timer;
  logic [6:0]       r_seed;
  logic             r_armed;

  logic [NUM_Q-1:0] w_win_oh;
  logic [QW-1:0]    w_win_idx;
  logic             w_win_valid;
  logic [NUM_Q-1:0] w_active_oh;
  logic [23:0]      w_timer_inc;
  logic [7:0]       w_gap_len;
  logic             w_start_expired;
  logic             w_done_expired;
  logic             w_gap_end;

  rr_arbiter #(
    .NUM_Q (NUM_Q),
    .QW    (QW)
  ) u_rr_arbiter (
    .i_req        (req),
    .i_rr_ptr     (r_rr_ptr),
    .o_winner_oh  (w_win_oh),
    .o_winner_idx (w_win_idx),
    .o_valid      (w_win_valid)
  );

  always_comb begin
    w_active_oh             = '0;
    w_active_oh[r_active_q] = 1'b1;
  end

  // w_timer_inc counts the current cycle too, so a limit of N fires on cycle N.
  assign w_timer_inc     = (r_timer == 24'hFF_FFFF) ? r_timer : r_timer + 24'd1;
  assign w_gap_len       = (gap_cycles == 8'd0) ? 8'd1 : gap_cycles;
  assign w_start_expired = (start_timeout != 16'd0) && (w_timer_inc >= {8'd0, start_timeout});
  assign w_done_expired  = (done_timeout != 24'd0) && (w_timer_inc >= done_timeout);
  assign w_gap_end       = (w_timer_inc >= {16'd0, w_gap_len});

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_done     <= '0;
      r_err      <= '0;
      r_active_q <= '0;
      r_rr_ptr   <= '0;
      r_timer    <= '0;
      r_seed     <= SCRAM_SEED_INIT;
      r_armed    <= 1'b0;
    end else begin
      r_grant <= '0;
      r_done  <= '0;
      r_err   <= '0;
      // Holds off the first grant until the second edge after reset release.
      r_armed <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (r_armed && enable && w_win_valid) begin
            r_grant    <= w_win_oh;
            r_active_q <= w_win_idx;
            r_rr_ptr   <= w_win_idx + 1'b1;
            r_timer    <= '0;
            r_state    <= ST_START;
          end
        end

        ST_START: begin
          r_state <= ST_WAIT_STARTED;
        end

        ST_WAIT_STARTED: begin
          if (phy.phy_tx_started && phy.phy_tx_done) begin
            r_done  <= w_active_oh;
            r_seed  <= scram_step(r_seed);
            r_timer <= '0;
            r_state <= ST_GAP;
          end else if (phy.phy_tx_started) begin
            r_timer <= '0;
            r_state <= ST_WAIT_DONE;
          end else if (w_start_expired) begin
            r_err   <= w_active_oh;
            r_timer <= '0;
            r_state <= ST_GAP;
          end else begin
            r_timer <= w_timer_inc;
          end
        end

        ST_WAIT_DONE: begin
          if (phy.phy_tx_done) begin
            r_done  <= w_active_oh;
            r_seed  <= scram_step(r_seed);
            r_timer <= '0;
            r_state <= ST_GAP;
          end else if (w_done_expired) begin
            r_err   <= w_active_oh;
            r_timer <= '0;
            r_state <= ST_GAP;
          end else begin
            r_timer <= w_timer_inc;
          end
        end

        ST_GAP: begin
          if (w_gap_end) begin
            r_timer <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_timer <= w_timer_inc;
          end
        end

        default: begin
          r_timer <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant    = r_grant;
  assign done     = r_done;
  assign err      = r_err;
  assign active_q = r_active_q;
  assign busy     = (r_state != ST_IDLE);

  assign phy.phy_tx_start           = (r_state == ST_START) || (r_state == ST_WAIT_STARTED);
  assign phy.init_data_scram_state  = r_seed;
  assign phy.init_pilot_scram_state = SCRAM_SEED_INIT;

endmodule
`default_nettype wire

// File: tb/tb_dot11_tx_sched.sv
`default_nettype none
// ============================================================================
// tb_dot11_tx_sched : directed self-checking bench for dot11_tx_sched.
// Rev 1.0
// ============================================================================
module tb_dot11_tx_sched;

  logic        clk;
  logic        rstn;
  logic        enable;
  logic [3:0]  req;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic [3:0]  err;
  logic [1:0]  active_q;
  logic        busy;
  logic [15:0] start_timeout;
  logic [23:0] done_timeout;
  logic [7:0]  gap_cycles;

  int n_vec;
  int n_err;
  int q_cyc;
  int no_grant;

  dot11_tx_sched_if phy_if ();

  dot11_tx_sched #(
    .NUM_Q (4),
    .QW    (2)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .enable        (enable),
    .req           (req),
    .grant         (grant),
    .done          (done),
    .err           (err),
    .active_q      (active_q),
    .busy          (busy),
    .start_timeout (start_timeout),
    .done_timeout  (done_timeout),
    .gap_cycles    (gap_cycles),
    .phy           (phy_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns with the bench sitting in the cycle where grant is visible.
  task automatic wait_grant(output int cyc);
    cyc = 0;
    while (grant == 4'b0000 && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  // Called from the START cycle; t_st/t_dn are cycles after start.
  task automatic phy_serve(input int t_st, input int t_dn);
    repeat (t_st) tick();
    phy_if.phy_tx_started = 1'b1;
    tick();
    phy_if.phy_tx_started = 1'b0;
    repeat (t_dn - t_st - 1) tick();
    phy_if.phy_tx_done = 1'b1;
    tick();
    phy_if.phy_tx_done = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rstn = 1'b0;
    enable = 1'b0;
    req = 4'b0000;
    start_timeout = 16'd0;
    done_timeout = 24'd0;
    gap_cycles = 8'd5;
    phy_if.phy_tx_started = 1'b0;
    phy_if.phy_tx_done = 1'b0;

    repeat (3) tick();
    check("rst_grant", grant, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_start", phy_if.phy_tx_start, 1'b0);
    check("rst_seed", phy_if.init_data_scram_state, 7'h7F);
    check("pilot_seed", phy_if.init_pilot_scram_state, 7'h7F);

    // Test 1: two requesters, normal completion
    enable = 1'b1;
    req = 4'b0101;
    rstn = 1'b1;
    tick();
    check("t1_no_grant_edge1", grant, 4'b0000);
    wait_grant(q_cyc);
    check("t1_grant_q0", grant, 4'b0001);
    check("t1_active_q0", active_q, 2'd0);
    check("t1_phy_start", phy_if.phy_tx_start, 1'b1);
    check("t1_seed0", phy_if.init_data_scram_state, 7'h7F);
    req = 4'b0100;
    phy_serve(3, 50);
    check("t1_done_q0", done, 4'b0001);
    check("t1_err_none", err, 4'b0000);
    wait_grant(q_cyc);
    check("t1_grant_q2", grant, 4'b0100);
    check("t1_seed1", phy_if.init_data_scram_state, 7'h7E);
    req = 4'b0000;
    phy_serve(3, 50);
    check("t1_done_q2", done, 4'b0100);
    check("t1_seed2", phy_if.init_data_scram_state, 7'h7C);

    // Test 2: start timeout
    start_timeout = 16'd10;
    req = 4'b0010;
    wait_grant(q_cyc);
    check("t2_grant_q1", grant, 4'b0010);
    req = 4'b0000;
    repeat (10) tick();
    check("t2_err_early", err, 4'b0000);
    check("t2_start_hi", phy_if.phy_tx_start, 1'b1);
    tick();
    check("t2_err_q1", err, 4'b0010);
    check("t2_start_lo", phy_if.phy_tx_start, 1'b0);
    check("t2_done_none", done, 4'b0000);
    check("t2_seed", phy_if.init_data_scram_state, 7'h7C);

    // Test 3: done timeout, then a normal packet
    start_timeout = 16'd0;
    done_timeout = 24'd1000;
    req = 4'b1000;
    wait_grant(q_cyc);
    check("t3_grant_q3", grant, 4'b1000);
    req = 4'b0000;
    repeat (2) tick();
    phy_if.phy_tx_started = 1'b1;
    tick();
    phy_if.phy_tx_started = 1'b0;
    repeat (999) tick();
    check("t3_err_early", err, 4'b0000);
    tick();
    check("t3_err_q3", err, 4'b1000);
    check("t3_seed", phy_if.init_data_scram_state, 7'h7C);
    done_timeout = 24'd0;
    req = 4'b0001;
    wait_grant(q_cyc);
    check("t3_grant_q0", grant, 4'b0001);
    req = 4'b0000;
    phy_serve(1, 5);
    check("t3_done_q0", done, 4'b0001);
    check("t3_seed_adv", phy_if.init_data_scram_state, 7'h78);

    // Test 5: reset during WAIT_DONE
    req = 4'b0100;
    wait_grant(q_cyc);
    check("t5_grant_q2", grant, 4'b0100);
    req = 4'b0000;
    repeat (2) tick();
    phy_if.phy_tx_started = 1'b1;
    tick();
    phy_if.phy_tx_started = 1'b0;
    repeat (5) tick();
    check("t5_busy_pre", busy, 1'b1);
    check("t5_active_pre", active_q, 2'd2);
    rstn = 1'b0;
    #1;
    check("t5_busy", busy, 1'b0);
    check("t5_active", active_q, 2'd0);
    check("t5_start", phy_if.phy_tx_start, 1'b0);
    check("t5_seed", phy_if.init_data_scram_state, 7'h7F);
    phy_if.phy_tx_done = 1'b1;
    repeat (2) tick();
    check("t5_done_none", done, 4'b0000);
    check("t5_err_none", err, 4'b0000);
    phy_if.phy_tx_done = 1'b0;

    // Test 4: four requesters held for eight packets
    req = 4'b1111;
    rstn = 1'b1;
    tick();
    check("t4_no_grant_edge1", grant, 4'b0000);
    for (int i = 0; i < 8; i++) begin
      wait_grant(q_cyc);
      check($sformatf("t4_grant_%0d", i), grant, 32'(4'b0001 << (i % 4)));
      if (i > 0) check($sformatf("t4_gap_%0d", i), q_cyc, 6);
      if (i == 7) req = 4'b0000;
      phy_serve(1, 3);
      check($sformatf("t4_done_%0d", i), done, 32'(4'b0001 << (i % 4)));
    end

    // Test 6: enable dropped mid-packet, then both strobes together
    req = 4'b0010;
    wait_grant(q_cyc);
    check("t6_grant_q1", grant, 4'b0010);
    req = 4'b0000;
    tick();
    enable = 1'b0;
    tick();
    phy_if.phy_tx_started = 1'b1;
    tick();
    phy_if.phy_tx_started = 1'b0;
    repeat (2) tick();
    phy_if.phy_tx_done = 1'b1;
    tick();
    phy_if.phy_tx_done = 1'b0;
    check("t6_done_q1", done, 4'b0010);
    req = 4'b0100;
    no_grant = 0;
    repeat (20) begin
      tick();
      if (grant != 4'b0000) no_grant++;
    end
    check("t6_no_grant_disabled", no_grant, 0);
    check("t6_idle", busy, 1'b0);
    enable = 1'b1;
    wait_grant(q_cyc);
    check("t6_grant_q2", grant, 4'b0100);
    req = 4'b0000;
    repeat (2) tick();
    phy_if.phy_tx_started = 1'b1;
    phy_if.phy_tx_done = 1'b1;
    tick();
    phy_if.phy_tx_started = 1'b0;
    phy_if.phy_tx_done = 1'b0;
    check("t6_both_done", done, 4'b0100);
    check("t6_both_gap", busy, 1'b1);
    check("t6_both_start_lo", phy_if.phy_tx_start, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dot11_tx_sched.md
DOT11_TX_SCHED -- requirements
Module: dot11_tx_sched

Interface
REQ-001 SHALL have parameter NUM_Q, default 4, number of transmit requesters (power of 2, 2..8).
REQ-002 SHALL have parameter QW, default $clog2(NUM_Q), width of the queue index.
REQ-003 SHALL have port clk, input, 1: single clock domain (200 MHz).
REQ-004 SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port enable, input, 1: arbitration allowed when high.
REQ-006 SHALL have port req, input, NUM_Q: level request per queue, held until that queue's grant.
REQ-007 SHALL have port grant, output, NUM_Q: one-hot, one-cycle pulse to the accepted queue.
REQ-008 SHALL have port done, output, NUM_Q: one-cycle pulse on successful completion.
REQ-009 SHALL have port err, output, NUM_Q: one-cycle pulse on timeout.
REQ-010 SHALL have port active_q, output, QW: index of the queue being served.
REQ-011 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-012 SHALL have port start_timeout, input, 16: maximum cycles from start to phy_tx_started.
REQ-013 SHALL have port done_timeout, input, 24: maximum cycles from phy_tx_started to phy_tx_done.
REQ-014 SHALL have port gap_cycles, input, 8: idle cycles inserted after each packet.
REQ-015 SHALL have port phy_tx_start, output, 1: start request to the OFDM transmitter.
REQ-016 SHALL have port phy_tx_started, input, 1: transmitter accepted the start.
REQ-017 SHALL have port phy_tx_done, input, 1: transmitter finished.
REQ-018 SHALL have port init_data_scram_state, output, 7: data scrambler seed per packet.
REQ-019 SHALL have port init_pilot_scram_state, output, 7: constant 7'h7F.

Function
REQ-020 SHALL implement FSM states IDLE, START, WAIT_STARTED, WAIT_DONE and GAP.
REQ-021 In IDLE with enable=1 and req!=0, SHALL select the winner round-robin from rr_ptr upward (wrapping), pulse grant[winner], register active_q, clear the timer and move to START, all in one edge.
REQ-022 After a grant, SHALL set rr_ptr to winner+1 modulo NUM_Q.
REQ-023 With a single requesting queue, SHALL serve that queue repeatedly.
REQ-024 SHALL drive phy_tx_start=1 in START and WAIT_STARTED only.
REQ-025 START SHALL last exactly one cycle, then go to WAIT_STARTED.
REQ-026 In WAIT_STARTED, on phy_tx_started=1 SHALL go to WAIT_DONE and clear the timer.
REQ-027 In WAIT_STARTED, when the timer reaches start_timeout SHALL pulse err[active_q] and go to GAP.
REQ-028 In WAIT_DONE, on phy_tx_done=1 SHALL pulse done[active_q], advance the scrambler seed and go to GAP.
REQ-029 In WAIT_DONE, when the timer reaches done_timeout SHALL pulse err[active_q] and go to GAP without advancing the seed.
REQ-030 If phy_tx_started and phy_tx_done are both high in WAIT_STARTED, SHALL treat the packet as complete (done pulse, seed advance, GAP).
REQ-031 A timeout value of 0 SHALL mean no timeout.
REQ-032 Timers SHALL saturate and SHALL NOT wrap.
REQ-033 GAP SHALL last max(gap_cycles,1) cycles, then return to IDLE.
REQ-034 Deasserting enable SHALL only block new grants; an in-flight packet completes normally.
REQ-035 Seed advance SHALL be one step of x^7+x^4+1 (new bit = s[6]^s[3], shifted into the LSB).
REQ-036 If a seed advance yields 7'h00, SHALL substitute 7'h7F.
REQ-037 grant, done and err SHALL never be asserted in the same cycle as each other.
REQ-038 At most one bit of each of grant, done and err SHALL be set at any time.

Reset
REQ-039 On rstn=0, immediately and regardless of state, SHALL force: state IDLE; grant, done, err = 0; phy_tx_start = 0; busy = 0; active_q = 0; rr_ptr = 0; timer = 0; init_data_scram_state = 7'h7F.
REQ-040 Reset mid-packet SHALL abandon the packet with no done or err pulse.
REQ-041 The first grant after reset release SHALL occur no earlier than the second clk edge with rstn=1.

Structure
REQ-042 SHALL take state encodings, the 7'h7F seed constant and the scrambler-step function from a shared package, dot11_tx_pkg.
REQ-043 SHALL contain one sub-module, rr_arbiter (req, rr_ptr -> one-hot winner + index, purely combinational); everything else is in the top module.

Verification
REQ-044 Test 1: req=4'b0101, stub asserts started 3 cycles and done 50 cycles after start -> grants to q0 then q2, done pulses in the same order, seeds 7'h7F then 7'h7E.
REQ-045 Test 2: start_timeout=10, started never asserted -> err[q] exactly 10 cycles after leaving START, phy_tx_start low afterwards, seed unchanged.
REQ-046 Test 3: done_timeout=1000, done never asserted -> err pulse at cycle 1000 of WAIT_DONE; the next request is then served normally.
REQ-047 Test 4: all four req held high for 8 packets -> grant order q0,q1,q2,q3,q0,q1,q2,q3, and gap_cycles=5 between each done and the next grant.
REQ-048 Test 5: rstn pulsed low during WAIT_DONE -> all outputs at reset values in the same cycle, and no done or err pulse.
REQ-049 Test 6: enable dropped during WAIT_STARTED -> the packet completes with a done pulse, and no grant follows until enable=1.
